// File: rtl/bp_me_lce_req_arbiter_pkg.sv
//-----------------------------------------------------------------------------
// Module  : bp_me_lce_req_arbiter_pkg
// Purpose : Shared types for the LCE request arbiter: processor config
//           selector, BedRock LCE request message layout, output register
//           state encoding and a width helper.
// Config  : none
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

package bp_me_lce_req_arbiter_pkg;

   // Processor configurations known to this slice
   typedef enum logic [3:0] {
      e_bp_unicore_half_cfg = 4'd0
   } bp_params_e;

   // Geometry of e_bp_unicore_half_cfg
   localparam int paddr_width_p     = 40;
   localparam int cce_block_width_p = 64;
   localparam int lce_id_width_p    = 4;
   localparam int cce_id_width_p    = 4;
   localparam int lce_assoc_p       = 8;

   typedef enum logic [2:0] {
      e_bedrock_req_rd_miss = 3'd0,
      e_bedrock_req_wr_miss = 3'd1,
      e_bedrock_req_uc_rd   = 3'd2,
      e_bedrock_req_uc_wr   = 3'd3
   } bp_bedrock_req_type_e;

   typedef struct packed {
      logic [cce_block_width_p-1:0]   data;
      logic [$clog2(lce_assoc_p)-1:0] lru_way_id;
      logic [lce_id_width_p-1:0]      src_id;
      logic [cce_id_width_p-1:0]      dst_id;
      logic [paddr_width_p-1:0]       addr;
      logic [1:0]                     size;
      bp_bedrock_req_type_e           msg_type;
   } bp_bedrock_lce_req_msg_s;

   // One-entry output register occupancy
   typedef enum logic [0:0] {
      e_arb_empty = 1'b0,
      e_arb_full  = 1'b1
   } bp_me_arb_state_e;

   // Packed LCE request width for a given processor config
   function automatic int lce_req_msg_width(bp_params_e cfg);
      case (cfg)
         e_bp_unicore_half_cfg: return $bits(bp_bedrock_lce_req_msg_s);
         default:               return $bits(bp_bedrock_lce_req_msg_s);
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/bp_me_lce_req_arbiter_if.sv
//-----------------------------------------------------------------------------
// Module  : bp_me_lce_req_arbiter_if
// Purpose : Bundle of the request-side and CCE-side handshake signals of the
//           LCE request arbiter.
//   lce_req_i/lce_req_v_i/lce_req_yumi_o : per-slot requests (valid-yumi)
//   lce_req_o/lce_req_v_o/lce_req_ready_then_i : merged output (ready-then-valid)
//   grant_id_o : slot index of the held message
//   slave modport = arbiter view, master modport = surrounding fabric view
// Config  : none
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

interface bp_me_lce_req_arbiter_if
   import bp_me_lce_req_arbiter_pkg::*;
 #(parameter int num_lce_p   = 2
  ,parameter int msg_width_p = lce_req_msg_width(e_bp_unicore_half_cfg)
  );

   logic [num_lce_p*msg_width_p-1:0] lce_req_i;
   logic [num_lce_p-1:0]             lce_req_v_i;
   logic [num_lce_p-1:0]             lce_req_yumi_o;
   logic [msg_width_p-1:0]           lce_req_o;
   logic                             lce_req_v_o;
   logic                             lce_req_ready_then_i;
   logic [$clog2(num_lce_p)-1:0]     grant_id_o;

   modport slave (
      input  lce_req_i, lce_req_v_i, lce_req_ready_then_i,
      output lce_req_yumi_o, lce_req_o, lce_req_v_o, grant_id_o
   );

   modport master (
      output lce_req_i, lce_req_v_i, lce_req_ready_then_i,
      input  lce_req_yumi_o, lce_req_o, lce_req_v_o, grant_id_o
   );

endinterface

`default_nettype wire

// File: rtl/bp_me_lce_req_arbiter_rr_pick.sv
//-----------------------------------------------------------------------------
// Module  : bp_me_rr_pick
// Purpose : Combinational rotate-priority selector. The search starts at the
//           slot after last_i and wraps; the first valid slot wins.
//   v_i        : per-slot request valid
//   last_i     : index of the most recent grant
//   grant_oh_o : one-hot grant (all zero when nothing is valid)
//   grant_id_o : index of the granted slot
//   grant_v_o  : a slot was selected
// Config  : none
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module bp_me_rr_pick
 #(parameter int num_p = 2
  ,localparam int id_width_lp = $clog2(num_p)
  )
  (input  logic [num_p-1:0]       v_i
  ,input  logic [id_width_lp-1:0] last_i
  ,output logic [num_p-1:0]       grant_oh_o
  ,output logic [id_width_lp-1:0] grant_id_o
  ,output logic                   grant_v_o
  );

   int w_idx;

   // Walk from the farthest candidate to the nearest so the nearest valid
   // slot is the last one written and therefore wins.
   always_comb begin
      grant_id_o = '0;
      grant_v_o  = 1'b0;
      w_idx      = 0;
      for (int off = num_p; off >= 1; off--) begin
         w_idx = int'(last_i) + off;
         if (w_idx >= num_p) w_idx = w_idx - num_p;
         if (v_i[w_idx]) begin
            grant_id_o = id_width_lp'(w_idx);
            grant_v_o  = 1'b1;
         end
      end
   end

   assign grant_oh_o = grant_v_o ? ({{(num_p-1){1'b0}}, 1'b1} << grant_id_o) : '0;

endmodule

`default_nettype wire

// File: rtl/bp_me_lce_req_arbiter.sv
//-----------------------------------------------------------------------------
// Module  : bp_me_lce_req_arbiter
// Purpose : Round-robin merge of num_lce_p LCE request streams into one
//           CCE-bound port through a one-entry output register, with a sticky
//           flag for requests whose src_id disagrees with their slot.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   bus (slave)      : requests in, merged request out, grant_id_o
//   src_err_o        : sticky src_id mismatch flag
//   stat_grants_o / stat_max_wait_o : per-slot statistics (optional)
// Config  : BP_ME_LCE_REQ_ARB_STATS_EN adds per-slot 32-bit saturating grant
//           counters and 16-bit saturating max-wait counters.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module bp_me_lce_req_arbiter
   import bp_me_lce_req_arbiter_pkg::*;
 #(parameter bp_params_e bp_params_p = e_bp_unicore_half_cfg
  ,parameter int num_lce_p     = 2
  ,parameter int lce_id_base_p = 0
  ,localparam int lce_req_msg_width_lp = lce_req_msg_width(bp_params_p)
  ,localparam int grant_id_width_lp    = $clog2(num_lce_p)
  )
  (input  logic                         clk_i
  ,input  logic                         reset_n_i
  ,bp_me_lce_req_arbiter_if.slave       bus
  ,output logic                         src_err_o
`ifdef BP_ME_LCE_REQ_ARB_STATS_EN
  ,output logic [num_lce_p*32-1:0]      stat_grants_o
  ,output logic [num_lce_p*16-1:0]      stat_max_wait_o
`endif
  );

   bp_me_arb_state_e                r_state, w_state_n;
   bp_bedrock_lce_req_msg_s         r_msg, w_sel_msg;
   logic [grant_id_width_lp-1:0]    r_grant_id, r_last_grant;
   logic                            r_src_err;

   logic [num_lce_p-1:0]            w_pick_oh, w_yumi;
   logic [grant_id_width_lp-1:0]    w_pick_id;
   logic                            w_pick_v, w_drain, w_load;
   logic [lce_id_width_p-1:0]       w_exp_src;

   bp_me_rr_pick #(.num_p(num_lce_p)) u_pick (
      .v_i        (bus.lce_req_v_i),
      .last_i     (r_last_grant),
      .grant_oh_o (w_pick_oh),
      .grant_id_o (w_pick_id),
      .grant_v_o  (w_pick_v)
   );

   assign w_sel_msg = bp_bedrock_lce_req_msg_s'(
      bus.lce_req_i[int'(w_pick_id)*lce_req_msg_width_lp +: lce_req_msg_width_lp]);
   assign w_exp_src = lce_id_width_p'(lce_id_base_p + int'(w_pick_id));

   // Occupancy FSM: a new grant is accepted when empty or when the held
   // message leaves this same cycle, giving one message per cycle.
   always_comb begin
      w_state_n = r_state;
      w_drain   = (r_state == e_arb_full) && bus.lce_req_ready_then_i;
      w_load    = ((r_state == e_arb_empty) || w_drain) && w_pick_v;
      if (w_load)       w_state_n = e_arb_full;
      else if (w_drain) w_state_n = e_arb_empty;
   end

   // Gate with the reset pin so no upstream message is taken while held in reset
   assign w_yumi = (w_load && reset_n_i) ? w_pick_oh : '0;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state      <= e_arb_empty;
         r_msg        <= '0;
         r_grant_id   <= '0;
         r_last_grant <= grant_id_width_lp'(num_lce_p - 1);
         r_src_err    <= 1'b0;
      end else begin
         r_state <= w_state_n;
         if (w_load) begin
            r_msg        <= w_sel_msg;
            r_grant_id   <= w_pick_id;
            r_last_grant <= w_pick_id;
            if (w_sel_msg.src_id != w_exp_src) r_src_err <= 1'b1;
         end
      end
   end

   assign bus.lce_req_yumi_o = w_yumi;
   assign bus.lce_req_o      = r_msg;
   assign bus.lce_req_v_o    = (r_state == e_arb_full);
   assign bus.grant_id_o     = r_grant_id;
   assign src_err_o          = r_src_err;

`ifdef BP_ME_LCE_REQ_ARB_STATS_EN
   for (genvar k = 0; k < num_lce_p; k++) begin : g_stats
      logic [31:0] r_grants;
      logic [15:0] r_cur_wait, r_max_wait, w_wait_inc;

      assign w_wait_inc = (r_cur_wait == 16'hFFFF) ? r_cur_wait : r_cur_wait + 16'd1;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            r_grants   <= '0;
            r_cur_wait <= '0;
            r_max_wait <= '0;
         end else begin
            if (w_yumi[k] && (r_grants != 32'hFFFF_FFFF)) r_grants <= r_grants + 32'd1;
            // A wait streak is the run of cycles valid but not granted
            if (bus.lce_req_v_i[k] && !w_yumi[k]) begin
               r_cur_wait <= w_wait_inc;
               if (w_wait_inc > r_max_wait) r_max_wait <= w_wait_inc;
            end else begin
               r_cur_wait <= '0;
            end
         end
      end

      assign stat_grants_o[k*32 +: 32]   = r_grants;
      assign stat_max_wait_o[k*16 +: 16] = r_max_wait;
   end
`endif

endmodule

`default_nettype wire
